// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter for the shared MMIO bus: round-robin grant, one-cycle strobe,
// fixed read latency, then a single ack pulse with captured read data to the winner.
module mmio_bus_arbiter #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wmask,
    output logic        s_we,
    output logic        s_re,
    input  logic [31:0] s_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    state_t      state_q;
    logic        owner_q;
    logic        last_grant_q;
    logic        we_q;
    logic [3:0]  cnt_q;
    logic        m0_ack_q;
    logic        m1_ack_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic [31:0] s_addr_q;
    logic [31:0] s_wdata_q;
    logic [3:0]  s_wmask_q;
    logic        s_we_q;
    logic        s_re_q;
    logic        busy_q;

    logic        grant_valid;
    logic        grant_sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wmask;
    logic        resp_go;

    // On a tie the requester that did not win last time gets the bus.
    always_comb begin
        grant_valid = m0_req | m1_req;
        grant_sel   = 1'b0;
        if (m0_req && m1_req) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = ~m0_req;
        end
    end

    always_comb begin
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_wmask = m0_wmask;
        if (grant_sel) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_wmask = m1_wmask;
        end
    end

    // Ack and read data are registered on the edge that enters RESP, so s_rdata is
    // captured in the last strobe/wait cycle and is visible together with the ack.
    assign resp_go = ((state_q == STROBE) && (LAT == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            cnt_q        <= 4'd0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= 32'd0;
            m1_rdata_q   <= 32'd0;
            s_addr_q     <= 32'd0;
            s_wdata_q    <= 32'd0;
            s_wmask_q    <= 4'd0;
            s_we_q       <= 1'b0;
            s_re_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            s_we_q   <= 1'b0;
            s_re_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q      <= grant_sel;
                        last_grant_q <= grant_sel;
                        we_q         <= sel_we;
                        s_addr_q     <= sel_addr;
                        s_wdata_q    <= sel_wdata;
                        s_wmask_q    <= sel_wmask;
                        s_we_q       <= sel_we;
                        s_re_q       <= ~sel_we;
                        busy_q       <= 1'b1;
                        state_q      <= STROBE;
                    end
                end
                STROBE: begin
                    if (LAT != 0) begin
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase

            if (resp_go) begin
                state_q <= RESP;
                if (owner_q) begin
                    m1_ack_q <= 1'b1;
                    if (!we_q) begin
                        m1_rdata_q <= s_rdata;
                    end
                end else begin
                    m0_ack_q <= 1'b1;
                    if (!we_q) begin
                        m0_rdata_q <= s_rdata;
                    end
                end
            end
        end
    end

    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wmask  = s_wmask_q;
    assign s_we     = s_we_q;
    assign s_re     = s_re_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: three builds (LAT=1, 0, 4) driven by directed and random
// accesses, checked cycle by cycle against a transaction-level timing/arbitration model.
`timescale 1ns/1ps
module tb_mmio_bus_arbiter;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [NI];
    logic        m0_req   [NI];
    logic        m0_we    [NI];
    logic [31:0] m0_addr  [NI];
    logic [31:0] m0_wdata [NI];
    logic [3:0]  m0_wmask [NI];
    logic        m0_ack   [NI];
    logic [31:0] m0_rdata [NI];
    logic        m1_req   [NI];
    logic        m1_we    [NI];
    logic [31:0] m1_addr  [NI];
    logic [31:0] m1_wdata [NI];
    logic [3:0]  m1_wmask [NI];
    logic        m1_ack   [NI];
    logic [31:0] m1_rdata [NI];
    logic [31:0] s_addr   [NI];
    logic [31:0] s_wdata  [NI];
    logic [3:0]  s_wmask  [NI];
    logic        s_we     [NI];
    logic        s_re     [NI];
    logic [31:0] s_rdata  [NI];
    logic        busy     [NI];

    int total = 0;
    int bad   = 0;

    // Model state: who won last, and what each port's read data register should hold.
    bit          last_g  [NI];
    logic [31:0] exp_rd0 [NI];
    logic [31:0] exp_rd1 [NI];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 4;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        mmio_bus_arbiter #(.LAT((gi == 0) ? 1 : (gi == 1) ? 0 : 4)) u_dut (
            .clk      (clk),
            .rst      (rst[gi]),
            .m0_req   (m0_req[gi]),
            .m0_we    (m0_we[gi]),
            .m0_addr  (m0_addr[gi]),
            .m0_wdata (m0_wdata[gi]),
            .m0_wmask (m0_wmask[gi]),
            .m0_ack   (m0_ack[gi]),
            .m0_rdata (m0_rdata[gi]),
            .m1_req   (m1_req[gi]),
            .m1_we    (m1_we[gi]),
            .m1_addr  (m1_addr[gi]),
            .m1_wdata (m1_wdata[gi]),
            .m1_wmask (m1_wmask[gi]),
            .m1_ack   (m1_ack[gi]),
            .m1_rdata (m1_rdata[gi]),
            .s_addr   (s_addr[gi]),
            .s_wdata  (s_wdata[gi]),
            .s_wmask  (s_wmask[gi]),
            .s_we     (s_we[gi]),
            .s_re     (s_re[gi]),
            .s_rdata  (s_rdata[gi]),
            .busy     (busy[gi])
        );
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s (lat%0d build): observed %h expected %h", tag, lat_of(k), obs, exp);
        end
    endtask

    task automatic chk_rdata(input int k);
        chk("m0_rdata", k, m0_rdata[k], exp_rd0[k]);
        chk("m1_rdata", k, m1_rdata[k], exp_rd1[k]);
    endtask

    task automatic model_reset(input int k);
        last_g[k]  = 1'b1;
        exp_rd0[k] = 32'd0;
        exp_rd1[k] = 32'd0;
    endtask

    task automatic raise(input int k, input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] wm);
        if (!port) begin
            m0_req[k] = 1'b1; m0_we[k] = we; m0_addr[k] = addr; m0_wdata[k] = wd; m0_wmask[k] = wm;
        end else begin
            m1_req[k] = 1'b1; m1_we[k] = we; m1_addr[k] = addr; m1_wdata[k] = wd; m1_wmask[k] = wm;
        end
    endtask

    task automatic raise_rand(input int k, input bit port);
        logic [31:0] a;
        a = {8'h00, 4'($urandom_range(0, 7)), 20'($urandom)};
        raise(k, port, 1'($urandom), a, $urandom, 4'($urandom));
    endtask

    task automatic do_reset(input int k);
        @(negedge clk);
        rst[k] = 1'b1;
        @(posedge clk); #1;
        model_reset(k);
        chk("rst_busy", k, busy[k], 0);
        chk("rst_s_re", k, s_re[k], 0);
        chk("rst_s_we", k, s_we[k], 0);
        chk("rst_m0_ack", k, m0_ack[k], 0);
        chk("rst_m1_ack", k, m1_ack[k], 0);
        chk("rst_s_addr", k, s_addr[k], 0);
        chk("rst_s_wdata", k, s_wdata[k], 0);
        chk("rst_s_wmask", k, s_wmask[k], 0);
        chk_rdata(k);
        @(negedge clk);
        rst[k] = 1'b0;
    endtask

    // One complete access: called between edges with the DUT idle and at least one req high.
    task automatic run(input int k, input bit force_rd, input logic [31:0] rd_val);
        int          lat;
        bit          w;
        bit          we;
        logic [31:0] a, wd, smp;
        logic [3:0]  wm;
        lat = lat_of(k);
        if (m0_req[k] && m1_req[k]) w = !last_g[k];
        else                        w = !m0_req[k];
        last_g[k] = w;
        we = w ? m1_we[k]    : m0_we[k];
        a  = w ? m1_addr[k]  : m0_addr[k];
        wd = w ? m1_wdata[k] : m0_wdata[k];
        wm = w ? m1_wmask[k] : m0_wmask[k];
        s_rdata[k] = $urandom;
        @(posedge clk); #1;
        chk("strobe_s_re", k, s_re[k], !we);
        chk("strobe_s_we", k, s_we[k], we);
        chk("strobe_s_addr", k, s_addr[k], a);
        chk("strobe_s_wdata", k, s_wdata[k], wd);
        chk("strobe_s_wmask", k, s_wmask[k], wm);
        chk("strobe_busy", k, busy[k], 1);
        chk("strobe_m0_ack", k, m0_ack[k], 0);
        chk("strobe_m1_ack", k, m1_ack[k], 0);
        chk_rdata(k);
        for (int i = 1; i <= lat + 1; i++) begin
            @(negedge clk);
            smp = (force_rd && i == lat + 1) ? rd_val : $urandom;
            s_rdata[k] = smp;
            @(posedge clk); #1;
            if (i == lat + 1 && !we) begin
                if (w) exp_rd1[k] = smp;
                else   exp_rd0[k] = smp;
            end
            chk("post_s_re", k, s_re[k], 0);
            chk("post_s_we", k, s_we[k], 0);
            chk("hold_s_addr", k, s_addr[k], a);
            chk("hold_s_wdata", k, s_wdata[k], wd);
            chk("post_busy", k, busy[k], 1);
            chk("m0_ack", k, m0_ack[k], (i == lat + 1) && !w);
            chk("m1_ack", k, m1_ack[k], (i == lat + 1) && w);
            chk_rdata(k);
        end
        @(negedge clk);
        if (w) m1_req[k] = 1'b0;
        else   m0_req[k] = 1'b0;
        s_rdata[k] = $urandom;
        @(posedge clk); #1;
        chk("idle_busy", k, busy[k], 0);
        chk("idle_m0_ack", k, m0_ack[k], 0);
        chk("idle_m1_ack", k, m1_ack[k], 0);
        chk("idle_s_re", k, s_re[k], 0);
        chk("idle_s_we", k, s_we[k], 0);
        chk_rdata(k);
        $display("access lat%0d: owner=m%0d we=%0d addr=%h rdata0=%h rdata1=%h",
                 lat, w, we, a, exp_rd0[k], exp_rd1[k]);
    endtask

    task automatic drain(input int k);
        while (m0_req[k] || m1_req[k]) run(k, 1'b0, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1;
            m0_req[k] = 1'b0; m0_we[k] = 1'b0; m0_addr[k] = '0; m0_wdata[k] = '0; m0_wmask[k] = '0;
            m1_req[k] = 1'b0; m1_we[k] = 1'b0; m1_addr[k] = '0; m1_wdata[k] = '0; m1_wmask[k] = '0;
            s_rdata[k] = '0;
            model_reset(k);
        end
        for (int k = 0; k < NI; k++) do_reset(k);

        // m0 read from the keyboard-style region, LAT=1
        raise(0, 1'b0, 1'b0, 32'h0050_0000, 32'd0, 4'h0);
        run(0, 1'b1, 32'h0000_0041);

        // m1 full-word write
        raise(0, 1'b1, 1'b1, 32'h0070_0000, 32'h1234_5678, 4'hF);
        run(0, 1'b0, 32'd0);

        // Both requesting from the first cycle after reset: grants alternate m0, m1, m0, m1
        do_reset(0);
        raise_rand(0, 1'b0);
        raise_rand(0, 1'b1);
        run(0, 1'b0, 32'd0);
        raise_rand(0, 1'b0);
        run(0, 1'b0, 32'd0);
        raise_rand(0, 1'b1);
        run(0, 1'b0, 32'd0);
        raise_rand(0, 1'b0);
        run(0, 1'b0, 32'd0);
        drain(0);

        // LAT=0 read
        raise(1, 1'b0, 1'b0, 32'h0010_0000, 32'd0, 4'h0);
        run(1, 1'b1, 32'hDEAD_BEEF);

        // Reset during the wait phase of an m1 read, LAT=4
        raise(2, 1'b1, 1'b0, 32'h0040_0010, 32'd0, 4'h0);
        @(posedge clk); #1;
        chk("abort_strobe_s_re", 2, s_re[2], 1);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_wait_busy", 2, busy[2], 1);
        @(negedge clk);
        rst[2] = 1'b1;
        @(posedge clk); #1;
        model_reset(2);
        chk("abort_busy", 2, busy[2], 0);
        chk("abort_m1_ack", 2, m1_ack[2], 0);
        chk("abort_m0_ack", 2, m0_ack[2], 0);
        chk("abort_s_re", 2, s_re[2], 0);
        chk("abort_s_we", 2, s_we[2], 0);
        chk("abort_s_addr", 2, s_addr[2], 0);
        chk_rdata(2);
        @(negedge clk);
        rst[2] = 1'b0;
        raise_rand(2, 1'b0);
        run(2, 1'b0, 32'd0);
        drain(2);

        // Back-to-back write then read of the same address by m0
        raise(0, 1'b0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'h3);
        run(0, 1'b0, 32'd0);
        raise(0, 1'b0, 1'b0, 32'h0000_0100, 32'd0, 4'h0);
        run(0, 1'b1, 32'h0000_F00D);

        // Random traffic on every build, including idle cycles with no requester
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 40; n++) begin
                if (!m0_req[k] && $urandom_range(0, 1) == 1) raise_rand(k, 1'b0);
                if (!m1_req[k] && $urandom_range(0, 1) == 1) raise_rand(k, 1'b1);
                if (m0_req[k] || m1_req[k]) begin
                    run(k, 1'b0, 32'd0);
                end else begin
                    @(posedge clk); #1;
                    chk("noreq_busy", k, busy[k], 0);
                    chk("noreq_s_re", k, s_re[k], 0);
                    chk("noreq_s_we", k, s_we[k], 0);
                end
            end
            drain(k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
- Shares the single memory-mapped I/O bus between two requesters: m0 (CPU load/store unit) and m1 (DMA / console-scroll engine).
- The bus covers dmem, seg, kbd, timer, cmem, vga, led and sw, as decoded by addr[23:20].
- The block grants one requester at a time, drives a stable address with a single-cycle read/write strobe, and waits a fixed number of cycles for read data.
- It returns an ack pulse and captured read data to the winner.
- It sits between the requesters and the address decoder/peripheral read mux.

Parameters:
- LAT, 1, wait cycles after the strobe cycle before s_rdata is sampled; legal range 0..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  m0 access request; held until m0_ack
- m0_we  in  1  m0 write (1) / read (0)
- m0_addr  in  32  m0 byte address
- m0_wdata  in  32  m0 write data
- m0_wmask  in  4  m0 byte enables
- m0_ack  out  1  one-cycle completion pulse to m0
- m0_rdata  out  32  m0 read data, valid from the m0_ack cycle
- m1_req, m1_we, m1_addr, m1_wdata, m1_wmask  in  1/1/32/32/4  same meaning for m1
- m1_ack  out  1  one-cycle completion pulse to m1
- m1_rdata  out  32  m1 read data, valid from the m1_ack cycle
- s_addr  out  32  bus address; held for the whole access
- s_wdata  out  32  bus write data
- s_wmask  out  4  bus byte enables
- s_we  out  1  write strobe
- s_re  out  1  read strobe
- s_rdata  in  32  read data from the peripheral read mux
- busy  out  1  access in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock domain; all outputs are registered.
- Reset state:
  - state = IDLE, last_grant = 1, so m0 wins the first tie.
  - Both acks = 0, s_we = 0, s_re = 0, busy = 0.
  - s_addr, s_wdata and s_wmask = 0; m0_rdata = 0, m1_rdata = 0.
  - Reset in any state aborts the access immediately; no ack is issued for it.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester opposite last_grant (round-robin).
  - On grant: latch addr/wdata/wmask/we into s_*; record the owner; set last_grant = owner; go to STROBE.
  - If no req is high, stay in IDLE.
- STROBE (exactly 1 cycle):
  - s_re = ~we or s_we = we; the other strobe is 0.
  - If LAT = 0, go to RESP; else load cnt = LAT - 1 and go to WAIT.
- WAIT:
  - Strobes are 0 and s_addr is held.
  - If cnt == 0, go to RESP; else decrement cnt.
- RESP (1 cycle):
  - Owner's ack = 1.
  - For a read, owner rdata <= s_rdata, sampled in this cycle and visible in the ack cycle. This requires a registered ack/rdata update on the transition into RESP.
  - For a write, rdata is unchanged.
  - Next state is IDLE.
- Timing:
  - req first sampled high in IDLE at cycle t.
  - Strobe at t+1.
  - ack at t+2+LAT. For LAT = 0, ack is at t+2 and s_rdata is sampled at the end of t+1.
  - Throughput is one access per LAT+3 cycles.
- Strobe rules:
  - Exactly one strobe cycle per access, so side-effecting reads (kbd pop) and writes never repeat.
  - s_we and s_re are never both high.
- Requester protocol:
  - req, we, addr, wdata and wmask stay stable until ack.
  - A req still high in the cycle after ack is a new request.
- Fairness:
  - The non-owner's req is ignored until IDLE.
  - With both requesting continuously, grants strictly alternate.
- Isolation:
  - The non-owner's ack and rdata are never disturbed.
  - Requests arriving mid-access wait in the requester; nothing is queued inside the block.
- Byte enables: wmask is passed through unchanged; no address alignment checks.

Test Plan:
- m0 read, LAT=1, 0x0050_0000, s_rdata=0x0000_0041 → s_re at t+1 with s_addr=0x0050_0000; m0_ack at t+3 with m0_rdata=0x41; m1_ack stays 0.
- m1 write of 0x1234_5678 to 0x0070_0000, wmask=0xF → s_we high for exactly one cycle; s_addr/s_wdata held until m1_ack; m1_rdata unchanged.
- Both reqs high in the first cycle after reset, held continuously for 4 accesses → grant order m0, m1, m0, m1; each ack goes to the correct port only.
- LAT=0 build, m0 read with s_rdata=0xDEAD_BEEF → strobe at t+1, m0_ack at t+2 with rdata=0xDEADBEEF.
- rst asserted in the WAIT state of an m1 read (LAT=4) → next cycle: state IDLE, no ack, strobes 0, busy 0; a following simultaneous request is granted to m0.
- m0 write immediately followed by an m0 read to the same address, no m1 traffic → two separate strobes; back-to-back spacing is LAT+3 cycles.
